// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage sitting directly behind the PC.
// Requests the word at iaddr over a req/ack handshake, buffers {pc, instr}
// pairs in a DEPTH-entry FIFO toward decode, and drives the PC hold line so
// the PC advances exactly once per accepted fetch. Supports redirect flush
// and a sticky halt that only rst clears.
// Optional macro FETCH_PERF_EN adds fetch/stall/flush performance counters.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
`ifdef FETCH_PERF_EN
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   stall_cnt,
    output logic [7:0]    flush_cnt,
`endif
    input  logic          rst,
    input  logic [AW-1:0] iaddr,
    input  logic          redirect,
    input  logic          halt_req,
    output logic          pc_stall,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_FULL   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [AW-1:0] mem_pc_q  [DEPTH];
    logic [DW-1:0] mem_ins_q [DEPTH];

    logic halted;
    logic accept;
    logic pop;
    logic flush;

    // Handshake, PC hold and FIFO head outputs, all combinational from state
    always_comb begin
        halted      = (state_q == S_HALTED);
        imem_req    = (state_q == S_FETCH) & ~redirect & ~halt_req & ~rst;
        imem_addr   = iaddr;
        accept      = imem_req & imem_ack;
        instr_valid = (count_q != '0) & ~rst;
        pop         = instr_valid & instr_ready;
        // A redirect seen while halted is ignored: the PC is frozen, so the
        // queued instructions remain on the only path that will ever run.
        flush       = redirect & ~halted;
        pc_stall    = rst | halted | ~(accept | redirect);
        instr       = mem_ins_q[rd_ptr_q];
        instr_pc    = mem_pc_q[rd_ptr_q];
    end

    // Next-state for occupancy, pointers and the fetch state machine
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            // Flush discards any same-cycle pop; accept is already blocked.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = halt_req ? S_HALTED : S_FETCH;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (halted | halt_req) begin
                state_d = S_HALTED;
            end else if ((state_q == S_FULL) && pop) begin
                state_d = S_FETCH;
            end else if ((state_q == S_FETCH) && accept && !pop &&
                         (count_q == FULL_CNT - CW'(1))) begin
                state_d = S_FULL;
            end
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage; data only, written on every accepted fetch
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_pc_q[wr_ptr_q]  <= iaddr;
            mem_ins_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;

    // Counter increments; imem_req and flush are already zero when halted
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 16'(accept);
        stall_cnt_d = stall_cnt_q + 16'(imem_req & ~imem_ack);
        flush_cnt_d = flush_cnt_q + 8'(flush);
    end

    // Performance counter registers, wrapping on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the PC's current iaddr and requests that word from instruction memory over a req/ack handshake.
- Buffers each returned {pc, instruction} pair in a DEPTH-entry FIFO and presents it to decode with valid/ready.
- Drives the PC hold input (pc_stall), so the PC advances exactly once per accepted fetch. Handles redirect flush and a sticky halt.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 16, instruction address width.
- DW, 16, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iaddr  in  AW  current PC value.
- redirect  in  1  same signal as the PC's alt_pc_ctrl; flushes the queue.
- halt_req  in  1  from decode; stop fetching permanently until rst.
- pc_stall  out  1  to the PC hold input; 1 = PC keeps iaddr.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address; always equals iaddr.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  DW  fetched instruction.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  DW  head instruction.
- instr_pc  out  AW  address of the head instruction.

Behaviour:
- Reset (rst=1 at a clock edge):
  - count, rd_ptr and wr_ptr cleared to 0; state set to FETCH.
  - While rst is high: instr_valid=0, imem_req=0, pc_stall=1.
- States:
  - FETCH: normal operation.
  - FULL: count==DEPTH.
  - HALTED: sticky.
- Transitions:
  - FETCH->FULL when a push makes count==DEPTH with no pop in the same cycle.
  - FULL->FETCH on any pop.
  - Any state->HALTED when halt_req=1; only rst leaves HALTED.
  - redirect in FULL returns to FETCH, because the FIFO empties.
- imem_req = (state==FETCH) & ~redirect & ~halt_req & ~rst.
  - imem_addr = iaddr, combinational.
  - Once asserted, imem_req stays high with a stable address until imem_ack, unless redirect or halt_req drops it.
  - imem_ack while imem_req=0 is ignored.
- Fetch accept = imem_req & imem_ack.
  - On accept, {iaddr, imem_rdata} is written at wr_ptr at the clock edge.
  - instr_valid is visible the next cycle: latency 1 cycle from ack to valid.
- pc_stall = ~(fetch accept | redirect).
  - The PC advances by exactly 1 per accepted fetch.
  - redirect forces pc_stall=0 so the PC loads alt_pc; the PC gives hold priority over redirect.
  - In HALTED, pc_stall=1 unconditionally, including during redirect.
- Pop = instr_valid & instr_ready; rd_ptr advances.
  - instr and instr_pc are the combinational FIFO head; undefined when instr_valid=0, and the bench must not check them then.
- Simultaneous push and pop: count unchanged, both pointers advance. Push is never attempted when count==DEPTH, because imem_req=0 in FULL.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- redirect=1 at a clock edge:
  - count, rd_ptr and wr_ptr are cleared.
  - Any ack or pop in that same cycle is discarded.
  - instr_valid=0 in the next cycle.
  - The first fetch at the new PC is issued in the cycle after redirect.
- halt_req=1 at a clock edge:
  - No further pushes.
  - FIFO contents are retained and still drain to decode.
  - An ack in the halt_req cycle is discarded.
- redirect and halt_req in the same cycle: the FIFO is flushed and the state goes to HALTED.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds output ports:
  - fetch_cnt, 16 bits: count of accepted fetches.
  - stall_cnt, 16 bits: cycles with imem_req=1 & imem_ack=0.
  - flush_cnt, 8 bits: count of redirects.
- All three counters clear on rst, wrap on overflow and do not count in HALTED.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset, imem_ack tied 1, instr_ready tied 1, iaddr starting at 0x0000 -> instr_valid rises 1 cycle after the first ack; instr_pc sequence 0x0000, 0x0001, 0x0002 on consecutive cycles; pc_stall=0 every cycle.
2. instr_ready=0, imem_ack=1, DEPTH=4 -> exactly 4 accepts; then imem_req=0 and pc_stall=1; iaddr holds 0x0004. Raise instr_ready -> one pop, then one new fetch of 0x0004.
3. imem_ack delayed 3 cycles per request -> imem_req held with constant imem_addr; pc_stall=1 for 3 cycles, then 0 for 1; stall_cnt increments by 3 when FETCH_PERF_EN is defined.
4. FIFO holding 0x0010..0x0012, redirect=1 with alt_pc=0x0040 -> instr_valid=0 next cycle; the next fetch address is 0x0040; the stale ack in the redirect cycle is not enqueued.
5. halt_req=1 with 2 entries queued -> both entries still pop in order; imem_req stays 0; pc_stall=1 for 20 cycles; a redirect has no effect; rst returns the block to FETCH.
6. rst asserted mid-stream with count=3 -> instr_valid=0 and count=0 after the edge; fetch resumes from the PC's reset value 0x0000.
